// File: rtl/rah_tx_packer_pkg.sv
// rah_tx_packer_pkg: shared widths for the RAH TX gearbox (packet, MIPI word, fill unit).
package rah_tx_packer_pkg;
    localparam int RAH_PACKET_WIDTH = 48;
    localparam int MIPI_TX_WIDTH    = 64;
    localparam int FILL_UNIT        = 16;
endpackage

// File: rtl/rah_tx_packer_if.sv
// rah_tx_packer_if: packet-in / word-out handshake bundle of the TX packer.
// Ports: in_valid/in_ready/in_data/in_last (packet side), out_valid/out_ready/
// out_data/out_last (word side), word_count (words since last completed flush).
// slave = packer view, master = source/sink view.
interface rah_tx_packer_if
    import rah_tx_packer_pkg::*;
#(
    parameter int DATA_WIDTH = RAH_PACKET_WIDTH,
    parameter int MIPI_WIDTH = MIPI_TX_WIDTH
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [MIPI_WIDTH-1:0] out_data;
    logic                  out_last;
    logic [15:0]           word_count;
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, word_count
    );
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, word_count
    );
endinterface

// File: rtl/rah_tx_packer.sv
// rah_tx_packer: packs 48-bit RAH packets LSB-first into 64-bit MIPI TX words.
// Ports: clk (tx pixel clock), rst_n (sync active-low reset),
// bus (rah_tx_packer_if.slave; parameters must match the interface instance).
module rah_tx_packer
    import rah_tx_packer_pkg::*;
#(
    parameter int DATA_WIDTH = RAH_PACKET_WIDTH,
    parameter int MIPI_WIDTH = MIPI_TX_WIDTH
) (
    input logic            clk,
    input logic            rst_n,
    rah_tx_packer_if.slave bus
);
    localparam int BW = DATA_WIDTH + MIPI_WIDTH;
    localparam int PU = DATA_WIDTH / FILL_UNIT;
    localparam int WU = MIPI_WIDTH / FILL_UNIT;
    localparam int FW = $clog2(BW / FILL_UNIT + 1);
    logic [BW-1:0] buf_q, buf_popped, buf_d;
    logic [FW-1:0] fill_q, fill_popped, fill_d;
    logic          flush_q, flush_d, push, pop, done;
    logic [15:0]   wc_q, wc_d;
    // Pop is applied first so a same-cycle push lands at the post-pop fill level.
    always_comb begin
        push        = bus.in_valid && bus.in_ready;
        pop         = bus.out_valid && bus.out_ready;
        fill_popped = pop ? (fill_q >= FW'(WU) ? fill_q - FW'(WU) : '0) : fill_q;
        buf_popped  = pop ? buf_q >> MIPI_WIDTH : buf_q;
        buf_d       = push ? buf_popped | (BW'(bus.in_data) << (fill_popped * FILL_UNIT)) : buf_popped;
        fill_d      = push ? fill_popped + FW'(PU) : fill_popped;
        done        = pop && flush_q && fill_popped == '0;
        flush_d     = (push && bus.in_last) ? 1'b1 : (done ? 1'b0 : flush_q);
        wc_d        = done ? '0 : (pop ? wc_q + 16'd1 : wc_q);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q   <= '0;
            fill_q  <= '0;
            flush_q <= 1'b0;
            wc_q    <= '0;
        end else begin
            buf_q   <= buf_d;
            fill_q  <= fill_d;
            flush_q <= flush_d;
            wc_q    <= wc_d;
        end
    end
    // While flushing no push is accepted, so fill <= one word means this pop empties the buffer.
    assign bus.in_ready   = fill_q <= FW'(WU) && !flush_q;
    assign bus.out_valid  = fill_q >= FW'(WU) || (flush_q && fill_q != '0);
    assign bus.out_data   = buf_q[MIPI_WIDTH-1:0];
    assign bus.out_last   = bus.out_valid && flush_q && fill_q <= FW'(WU);
    assign bus.word_count = wc_q;
endmodule

// File: tb/tb_rah_tx_packer.sv
// tb_rah_tx_packer: table-driven and scoreboard bench for rah_tx_packer.
module tb_rah_tx_packer;
    import rah_tx_packer_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    rah_tx_packer_if bus ();
    rah_tx_packer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [63:0] data;
        logic        last;
    } word_t;
    typedef struct {
        logic        v;
        logic [47:0] d;
        logic        l;
        logic        ordy;
        logic        ir;
        logic        ov;
        logic        ol;
        logic [63:0] od;
        logic [15:0] wc;
    } vec_t;

    word_t       q[$];
    vec_t        tbl[8];
    logic [191:0] acc;
    int          nbits = 0;
    int          checks = 0;
    int          errors = 0;
    int          pops = 0;
    int          stalls = 0;
    logic [15:0] wc_exp;
    logic        s_ir, s_ov, s_ol, took;
    logic [63:0] s_od;
    logic [15:0] s_wc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference unpacker view: concatenate packets as a bit stream, cut 64-bit words.
    task automatic model_push(input logic [47:0] d, input logic l);
        word_t w;
        acc |= 192'(d) << nbits;
        nbits += 48;
        while (nbits >= 64) begin
            q.push_back('{acc[63:0], 1'b0});
            acc >>= 64;
            nbits -= 64;
        end
        if (l) begin
            if (nbits > 0) begin
                q.push_back('{acc[63:0], 1'b1});
                acc = '0;
                nbits = 0;
            end else begin
                w = q.pop_back();
                w.last = 1'b1;
                q.push_back(w);
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [47:0] d, input logic l, input logic ordy);
        word_t w;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.out_ready = ordy;
        #1;
        s_ir = bus.in_ready;
        s_ov = bus.out_valid;
        s_ol = bus.out_last;
        s_od = bus.out_data;
        s_wc = bus.word_count;
        took = v && s_ir;
        if (v && !s_ir) stalls++;
        check("word_count", 64'(s_wc), 64'(wc_exp));
        if (!s_ov) check("out_last_idle", 64'(s_ol), 64'd0);
        if (q.size() == 0) begin
            check("spurious_valid", 64'(s_ov), 64'd0);
        end else if (s_ov) begin
            check("out_data", s_od, q[0].data);
            check("out_last", 64'(s_ol), 64'(q[0].last));
            if (ordy) begin
                w = q.pop_front();
                pops++;
                wc_exp = w.last ? 16'd0 : wc_exp + 16'd1;
            end
        end
        if (took) model_push(d, l);
    endtask

    task automatic send(input logic [47:0] d, input logic l, input logic ordy);
        int n = 0;
        do begin
            cycle(1'b1, d, l, ordy);
            n++;
        end while (!took && n < 50);
        if (!took) check("accept_timeout", 64'(took), 64'd1);
    endtask

    task automatic idle(input int n, input logic ordy);
        repeat (n) cycle(1'b0, 48'd0, 1'b0, ordy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        check("rst_out_data", bus.out_data, 64'd0);
        check("rst_word_count", 64'(bus.word_count), 64'd0);
        q.delete();
        acc = '0;
        nbits = 0;
        wc_exp = '0;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] d;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        acc = '0;
        wc_exp = '0;
        tbl[0] = '{1'b1, 48'hABCD_1234_5678, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 16'd0};
        tbl[1] = '{1'b0, 48'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0000_ABCD_1234_5678, 16'd0};
        tbl[2] = '{1'b0, 48'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 16'd0};
        tbl[3] = '{1'b1, 48'hA0A1_A2A3_A4A5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 16'd0};
        tbl[4] = '{1'b1, 48'hB0B1_B2B3_B4B5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0000_A0A1_A2A3_A4A5, 16'd0};
        tbl[5] = '{1'b0, 48'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'hB4B5_A0A1_A2A3_A4A5, 16'd0};
        tbl[6] = '{1'b0, 48'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0000_0000_B0B1_B2B3, 16'd1};
        tbl[7] = '{1'b0, 48'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 16'd0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].ordy);
            check($sformatf("tbl%0d_in_ready", i), 64'(s_ir), 64'(tbl[i].ir));
            check($sformatf("tbl%0d_out_valid", i), 64'(s_ov), 64'(tbl[i].ov));
            check($sformatf("tbl%0d_out_last", i), 64'(s_ol), 64'(tbl[i].ol));
            check($sformatf("tbl%0d_out_data", i), s_od, tbl[i].od);
            check($sformatf("tbl%0d_word_count", i), 64'(s_wc), 64'(tbl[i].wc));
        end
        do_reset();
        pops = 0;
        send(48'h0000_0000_AAAA, 1'b0, 1'b1);
        send(48'h1111_2222_3333, 1'b0, 1'b1);
        send(48'h4444_5555_6666, 1'b0, 1'b1);
        send(48'h7777_8888_9999, 1'b0, 1'b1);
        idle(6, 1'b1);
        check("abcd_words", 64'(pops), 64'd3);
        check("abcd_word_count", 64'(s_wc), 64'd3);
        pops = 0;
        stalls = 0;
        for (int i = 0; i < 400; i++) begin
            d = {16'($urandom), $urandom};
            send(d, 1'b0, 1'b1);
        end
        idle(6, 1'b1);
        check("stream_words", 64'(pops), 64'd300);
        check("stream_word_count", 64'(s_wc), 64'd303);
        check("stream_stalls_seen", 64'(stalls != 0), 64'd1);
        check("stream_drained", 64'(q.size()), 64'd0);
        send(48'hC0C0_0000_0001, 1'b0, 1'b1);
        send(48'hC0C0_0000_0002, 1'b0, 1'b1);
        send(48'hC0C0_0000_0003, 1'b0, 1'b1);
        send(48'hC0C0_0000_0004, 1'b0, 1'b1);
        send(48'hC0C0_0000_0005, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 48'd0, 1'b0, 1'b0);
            check("hold_in_ready", 64'(s_ir), 64'd0);
            check("hold_out_valid", 64'(s_ov), 64'd1);
        end
        idle(6, 1'b1);
        send(48'hC0C0_0000_0006, 1'b1, 1'b1);
        idle(4, 1'b1);
        check("hold_drained", 64'(q.size()), 64'd0);
        check("hold_flush_word_count", 64'(s_wc), 64'd0);
        send(48'hD0D0_0000_0001, 1'b0, 1'b0);
        send(48'hD0D0_0000_0002, 1'b0, 1'b0);
        idle(1, 1'b1);
        send(48'hD0D0_0000_0003, 1'b1, 1'b0);
        cycle(1'b0, 48'd0, 1'b0, 1'b0);
        check("pre_reset_out_valid", 64'(s_ov), 64'd1);
        do_reset();
        idle(4, 1'b1);
        check("post_reset_in_ready", 64'(s_ir), 64'd1);
        check("final_queue_empty", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
